if_pingpong_ctrl: RTL

Read/fill sequencer for the two ping-pong ifmap SRAM banks. It tracks the full or empty state of each bank and tells the DMA side which bank to fill next. It streams a filled bank out to the PE side by generating SRAM read enables, addresses, and the registered `data_valid`/`ifsram0_read`/`ifsram1_read` selects that steer the ifmap output mux, then releases the bank.

---
 rtl/if_pingpong_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/if_pingpong_ctrl.sv
// Ping-pong ifmap SRAM sequencer: tracks full/empty per bank, steers DMA fills,
// and streams a full bank to the PE side with a one-cycle read-latency pipeline.
module if_pingpong_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              fill_done,
    input  logic              rd_req,
    output logic              wr_bank,
    output logic              wr_ready,
    output logic              sram0_re,
    output logic              sram1_re,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              data_valid,
    output logic              ifsram0_read,
    output logic              ifsram1_read,
    output logic              rd_done,
    output logic [1:0]        bank_full,
    output logic              err_ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO = '0;

    logic [1:0]        state_reg, state_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic [1:0]        bank_full_reg, bank_full_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   len_reg, len_next;
    logic              err_ovf_reg, err_ovf_next;
    logic [1:0]        re_reg, re_next;
    logic [1:0]        rvalid_reg;
    logic              data_valid_reg;
    logic              rd_done_reg, rd_done_next;

    logic fill_ok;
    logic start;
    logic last_addr;
    logic release_bank;

    // A fill is only accepted into an empty bank; this also makes a fill into
    // the bank currently being read impossible, since that bank is full.
    assign fill_ok      = fill_done && !bank_full_reg[wr_ptr_reg];
    assign start        = (state_reg == IDLE) && rd_req && bank_full_reg[rd_ptr_reg];
    assign release_bank = (state_reg == DRAIN);
    // len is at least 1 whenever READ is entered, so len-1 never underflows.
    assign last_addr    = ({1'b0, addr_reg} == (len_reg - LEN_ONE));

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_len != LEN_ZERO) begin
                        state_next = READ;
                        len_next   = cfg_len;
                        addr_next  = '0;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            READ: begin
                if (last_addr) begin
                    state_next = DRAIN;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + ADDR_ONE;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    assign wr_ptr_next  = fill_ok ? ~wr_ptr_reg : wr_ptr_reg;
    assign rd_ptr_next  = release_bank ? ~rd_ptr_reg : rd_ptr_reg;
    assign err_ovf_next = err_ovf_reg | (fill_done && bank_full_reg[wr_ptr_reg]);
    assign rd_done_next = (state_next == DRAIN);

    // Per-bank full flag and address-phase enable; set and clear never hit the
    // same bank in one cycle because a released bank is still full.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_comb begin
                bank_full_next[gi] = bank_full_reg[gi];
                if (fill_ok && (wr_ptr_reg == 1'(gi))) begin
                    bank_full_next[gi] = 1'b1;
                end else if (release_bank && (rd_ptr_reg == 1'(gi))) begin
                    bank_full_next[gi] = 1'b0;
                end
            end
            assign re_next[gi] = (state_next == READ) && (rd_ptr_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            bank_full_reg  <= 2'b00;
            addr_reg       <= '0;
            len_reg        <= '0;
            err_ovf_reg    <= 1'b0;
            re_reg         <= 2'b00;
            rvalid_reg     <= 2'b00;
            data_valid_reg <= 1'b0;
            rd_done_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            bank_full_reg  <= bank_full_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            err_ovf_reg    <= err_ovf_next;
            re_reg         <= re_next;
            // Data phase trails the address phase by the SRAM read latency.
            rvalid_reg     <= re_reg;
            data_valid_reg <= |re_reg;
            rd_done_reg    <= rd_done_next;
        end
    end

    assign wr_bank      = wr_ptr_reg;
    assign wr_ready     = !bank_full_reg[wr_ptr_reg];
    assign bank_full    = bank_full_reg;
    assign sram0_re     = re_reg[0];
    assign sram1_re     = re_reg[1];
    assign rd_addr      = addr_reg;
    assign data_valid   = data_valid_reg;
    assign ifsram0_read = rvalid_reg[0];
    assign ifsram1_read = rvalid_reg[1];
    assign rd_done      = rd_done_reg;
    assign err_ovf      = err_ovf_reg;

endmodule
